morse_sequencer: RTL and testbench
==================================

MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 12500000, giving one Morse unit in iCLK cycles (250 ms at 50 MHz).
REQ-002 The block SHALL have parameter TONE_BIT, default 17, selecting the free-running counter bit that forms the audio tone.
REQ-003 The block SHALL have port iCLK  input  1  the single system clock; all logic on rising edge.
REQ-004 The block SHALL have port iRST  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port iCHAR  input  8  ASCII character to send.
REQ-006 The block SHALL have port iVALID  input  1  iCHAR valid.
REQ-007 The block SHALL have port oREADY  output  1  registered; block can accept a character.
REQ-008 The block SHALL have port oKEY  output  1  registered key line; 1 = mark (tone on).
REQ-009 The block SHALL have port oSOUND  output  1  oKEY AND counter bit TONE_BIT.
REQ-010 The block SHALL have port oBUSY  output  1  high whenever the state is not IDLE.

Function
REQ-011 The block SHALL accept a character on a rising edge where iVALID=1 and oREADY=1; oREADY SHALL drop on the following cycle.
REQ-012 The block SHALL use FSM states IDLE, LOAD, MARK, SPACE, CGAP and WGAP; oREADY=1 only in IDLE.
REQ-013 The block SHALL enter LOAD on acceptance; the code lookup SHALL be registered in LOAD.
REQ-014 The block SHALL support 'A'-'Z', 'a'-'z' (folded to upper case), '0'-'9' and space (0x20), with ITU Morse codes of 1-5 elements (1 = dash).
REQ-015 On an unsupported character, LOAD SHALL return to IDLE with no oKEY activity; oREADY SHALL be 1 two cycles after acceptance.
REQ-016 For a supported letter or digit, LOAD SHALL enter MARK; oKEY SHALL be 1 from the second edge after acceptance.
REQ-017 MARK SHALL hold oKEY=1 for exactly 1*UNIT_CYCLES cycles (dot) or 3*UNIT_CYCLES cycles (dash).
REQ-018 After a non-final element, SPACE SHALL hold oKEY=0 for 1*UNIT_CYCLES cycles, then return to MARK for the next element.
REQ-019 After the final element, CGAP SHALL hold oKEY=0 for 3*UNIT_CYCLES cycles, then go to IDLE.
REQ-020 For a space character, LOAD SHALL enter WGAP, hold oKEY=0 for 4*UNIT_CYCLES cycles, then go to IDLE; with the preceding CGAP this gives a 7-unit word gap.
REQ-021 The unit timer SHALL restart at every state entry, so durations are exact and there is no phase dependence on earlier characters.
REQ-022 Element length and pattern SHALL be held in a 3-bit count and a 5-bit shift register; the element index SHALL never wrap beyond the code length.
REQ-023 The tone counter SHALL be free-running, TONE_BIT+1 bits wide, and wrap naturally.
REQ-024 Changes on iVALID or iCHAR while oREADY=0 SHALL be ignored; no character SHALL be queued.
REQ-025 Back-to-back characters SHALL be supported: a character held valid at IDLE entry SHALL be accepted on the first IDLE edge.

Reset
REQ-026 While iRST=1, the block SHALL force state IDLE, oKEY=0, oSOUND=0, oBUSY=0, oREADY=0, and clear all timers and the tone counter.
REQ-027 oREADY SHALL rise at the first rising edge after iRST deasserts.
REQ-028 Reset during MARK, SPACE, CGAP or WGAP SHALL abort the character immediately; no partial element SHALL resume.

Structure
REQ-029 Shared package morse_pkg SHALL hold the FSM state encoding, the gap-length constants (1, 3, 4 units) and the code-length/pattern field widths.
REQ-030 Sub-module morse_rom (combinational, ASCII in -> {valid, len[2:0], pattern[4:0]} out) SHALL provide the code lookup.

Verification
REQ-031 The bench SHALL use UNIT_CYCLES=4 and TONE_BIT=1 for the directed cases below.
REQ-032 'E' -> oKEY high 4 cycles then low 12 cycles, then oREADY=1.
REQ-033 'a' -> oKEY high 4, low 4, high 12, low 12; identical to 'A'.
REQ-034 'S', ' ', 'T' streamed back-to-back -> oKEY pattern 4h/4l/4h/4l/4h/12l, then 16l, then 12h/12l; no extra idle cycles between characters.
REQ-035 '#' -> oKEY stays 0, oBUSY high for 2 cycles, oREADY=1 two cycles after acceptance.
REQ-036 '0' with iRST pulsed in the 2nd dash -> oKEY=0 asynchronously, oREADY=1 one edge after release; a following 'E' is sent correctly, with oSOUND toggling every 2 cycles only while oKEY=1.

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse sender.
// Holds the FSM state encoding, the element and gap lengths in Morse units,
// the code field widths and a helper that builds a ROM entry.
package morse_pkg;
    localparam int LEN_W       = 3;
    localparam int PAT_W       = 5;
    localparam int DOT_UNITS   = 1;
    localparam int DASH_UNITS  = 3;
    localparam int SPACE_UNITS = 1;
    localparam int CGAP_UNITS  = 3;
    localparam int WGAP_UNITS  = 4;

    typedef enum logic [2:0] {IDLE, LOAD, MARK, SPACE, CGAP, WGAP} stateT;

    typedef struct packed {
        logic             valid;
        logic [LEN_W-1:0] len;
        logic [PAT_W-1:0] pattern;
    } codeT;

    // codeBits lists the elements first-to-last in its low codeLen bits (1 = dash).
    // The pattern is stored left-aligned so the current element is always the MSB.
    function automatic codeT mkCode(input logic [LEN_W-1:0] codeLen, input logic [PAT_W-1:0] codeBits);
        return '{valid: 1'b1, len: codeLen, pattern: codeBits << (LEN_W'(PAT_W) - codeLen)};
    endfunction
endpackage

// File: rtl/morse_if.sv
// morse_if: character handshake and key outputs of the Morse sender.
// iCHAR/iVALID come from the character source; oREADY, oKEY, oSOUND and
// oBUSY are driven by the sequencer.
interface morse_if;
    logic [7:0] iCHAR;
    logic       iVALID;
    logic       oREADY;
    logic       oKEY;
    logic       oSOUND;
    logic       oBUSY;

    modport master (output iCHAR, iVALID, input oREADY, oKEY, oSOUND, oBUSY);
    modport slave  (input iCHAR, iVALID, output oREADY, oKEY, oSOUND, oBUSY);
endinterface

// File: rtl/morse_rom.sv
// morse_rom: combinational ASCII to Morse code lookup.
// Ports: iCHAR  ASCII character (lower case folded to upper case)
//        oCODE  {valid, len, pattern}; space is valid with len 0, anything
//               unsupported is all zeros.
module morse_rom
    import morse_pkg::*;
(
    input  logic [7:0] iCHAR,
    output codeT       oCODE
);
    logic [7:0] upper;

    always_comb begin
        upper = (iCHAR >= "a" && iCHAR <= "z") ? iCHAR - 8'd32 : iCHAR;
        case (upper)
            "A": oCODE = mkCode(3'd2, 5'b01);
            "B": oCODE = mkCode(3'd4, 5'b1000);
            "C": oCODE = mkCode(3'd4, 5'b1010);
            "D": oCODE = mkCode(3'd3, 5'b100);
            "E": oCODE = mkCode(3'd1, 5'b0);
            "F": oCODE = mkCode(3'd4, 5'b0010);
            "G": oCODE = mkCode(3'd3, 5'b110);
            "H": oCODE = mkCode(3'd4, 5'b0000);
            "I": oCODE = mkCode(3'd2, 5'b00);
            "J": oCODE = mkCode(3'd4, 5'b0111);
            "K": oCODE = mkCode(3'd3, 5'b101);
            "L": oCODE = mkCode(3'd4, 5'b0100);
            "M": oCODE = mkCode(3'd2, 5'b11);
            "N": oCODE = mkCode(3'd2, 5'b10);
            "O": oCODE = mkCode(3'd3, 5'b111);
            "P": oCODE = mkCode(3'd4, 5'b0110);
            "Q": oCODE = mkCode(3'd4, 5'b1101);
            "R": oCODE = mkCode(3'd3, 5'b010);
            "S": oCODE = mkCode(3'd3, 5'b000);
            "T": oCODE = mkCode(3'd1, 5'b1);
            "U": oCODE = mkCode(3'd3, 5'b001);
            "V": oCODE = mkCode(3'd4, 5'b0001);
            "W": oCODE = mkCode(3'd3, 5'b011);
            "X": oCODE = mkCode(3'd4, 5'b1001);
            "Y": oCODE = mkCode(3'd4, 5'b1011);
            "Z": oCODE = mkCode(3'd4, 5'b1100);
            "0": oCODE = mkCode(3'd5, 5'b11111);
            "1": oCODE = mkCode(3'd5, 5'b01111);
            "2": oCODE = mkCode(3'd5, 5'b00111);
            "3": oCODE = mkCode(3'd5, 5'b00011);
            "4": oCODE = mkCode(3'd5, 5'b00001);
            "5": oCODE = mkCode(3'd5, 5'b00000);
            "6": oCODE = mkCode(3'd5, 5'b10000);
            "7": oCODE = mkCode(3'd5, 5'b11000);
            "8": oCODE = mkCode(3'd5, 5'b11100);
            "9": oCODE = mkCode(3'd5, 5'b11110);
            " ": oCODE = '{valid: 1'b1, len: '0, pattern: '0};
            default: oCODE = '0;
        endcase
    end
endmodule

// File: rtl/morse_sequencer.sv
// morse_sequencer: sends one ASCII character at a time as Morse code.
// Ports: iCLK  system clock (rising edge)
//        iRST  asynchronous active-high reset
//        bus   morse_if.slave: iCHAR/iVALID in, oREADY/oKEY/oSOUND/oBUSY out
// Parameters: UNIT_CYCLES clock cycles per Morse unit, TONE_BIT tone counter bit.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12500000,
    parameter int TONE_BIT    = 17
) (
    input  logic   iCLK,
    input  logic   iRST,
    morse_if.slave bus
);
    localparam int TW = $clog2(WGAP_UNITS * UNIT_CYCLES);

    stateT            state, nextState;
    logic [TW-1:0]    timer;
    logic [7:0]       charReg;
    logic             codeValid;
    logic [LEN_W-1:0] elemLeft;
    logic [PAT_W-1:0] shiftReg;
    logic [TONE_BIT:0] toneCnt;
    codeT             romCode;
    int               durUnits;
    logic             lastCycle;

    morse_rom uRom (.iCHAR(charReg), .oCODE(romCode));

    assign bus.oBUSY  = state != IDLE;
    assign bus.oSOUND = bus.oKEY & toneCnt[TONE_BIT];

    // LOAD spends two cycles: the first registers the ROM output, the second
    // decides on the registered code.
    always_comb begin
        durUnits  = (state == MARK)  ? (shiftReg[PAT_W-1] ? DASH_UNITS : DOT_UNITS)
                  : (state == SPACE) ? SPACE_UNITS
                  : (state == CGAP)  ? CGAP_UNITS : WGAP_UNITS;
        lastCycle = timer == TW'(durUnits * UNIT_CYCLES - 1);
        nextState = state;
        case (state)
            IDLE:       if (bus.iVALID && bus.oREADY) nextState = LOAD;
            LOAD:       if (timer != '0) nextState = !codeValid ? IDLE : (elemLeft == '0) ? WGAP : MARK;
            MARK:       if (lastCycle) nextState = (elemLeft == LEN_W'(1)) ? CGAP : SPACE;
            SPACE:      if (lastCycle) nextState = MARK;
            CGAP, WGAP: if (lastCycle) nextState = IDLE;
            default:    nextState = IDLE;
        endcase
    end

    // oREADY and oKEY are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state      <= IDLE;
            timer      <= '0;
            charReg    <= '0;
            codeValid  <= 1'b0;
            elemLeft   <= '0;
            shiftReg   <= '0;
            toneCnt    <= '0;
            bus.oREADY <= 1'b0;
            bus.oKEY   <= 1'b0;
        end else begin
            state      <= nextState;
            timer      <= (nextState != state || state == IDLE) ? '0 : timer + 1'b1;
            toneCnt    <= toneCnt + 1'b1;
            bus.oREADY <= nextState == IDLE;
            bus.oKEY   <= nextState == MARK;
            if (state == IDLE && nextState == LOAD) charReg <= bus.iCHAR;
            if (state == LOAD && timer == '0) {codeValid, elemLeft, shiftReg} <= romCode;
            if (state == MARK && nextState != MARK) begin
                shiftReg <= shiftReg << 1;
                if (elemLeft != '0) elemLeft <= elemLeft - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_morse_sequencer.sv
// tb_morse_sequencer: self-checking bench for morse_sequencer.
// Expected key traces are built from a dot/dash text table and unit timing.
module tb_morse_sequencer;
    localparam int UNIT = 4;
    localparam int TB   = 1;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    morse_if bus();

    morse_sequencer #(.UNIT_CYCLES(UNIT), .TONE_BIT(TB)) dut (.iCLK(iCLK), .iRST(iRST), .bus(bus));

    always #5 iCLK = ~iCLK;

    int compared   = 0;
    int mismatched = 0;
    int tone       = 0;
    bit expKey[$];

    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                           "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                           "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digits[10]  = '{"-----", ".----", "..---", "...--", "....-",
                           ".....", "-....", "--...", "---..", "----."};

    task automatic step();
        @(posedge iCLK);
        if (!iRST) tone = (tone + 1) % (1 << (TB + 1));
        #1;
    endtask

    function automatic string codeOf(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
        if (u >= "A" && u <= "Z") return letters[u - "A"];
        if (u >= "0" && u <= "9") return digits[u - "0"];
        return (u == " ") ? "/" : "#";
    endfunction

    // Key level for every cycle from the acceptance edge until the block is idle again.
    task automatic buildExp(input logic [7:0] c);
        string s;
        s = codeOf(c);
        expKey.delete();
        expKey.push_back(1'b0);
        expKey.push_back(1'b0);
        if (s == "/") repeat (4 * UNIT) expKey.push_back(1'b0);
        else if (s != "#") for (int i = 0; i < s.len(); i++) begin
            repeat ((s[i] == "-" ? 3 : 1) * UNIT) expKey.push_back(1'b1);
            repeat ((i == s.len() - 1 ? 3 : 1) * UNIT) expKey.push_back(1'b0);
        end
    endtask

    task automatic sendChar(input logic [7:0] c);
        int n;
        logic expSound;
        n = 0;
        while (bus.oREADY !== 1'b1 && n < 200) begin step(); n++; end
        compared++;
        if (bus.oREADY !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_wait char=%h oREADY=%b required 1", c, bus.oREADY);
        end
        buildExp(c);
        bus.iCHAR  = c;
        bus.iVALID = 1'b1;
        step();
        for (int i = 0; i < expKey.size(); i++) begin
            bus.iVALID = 1'($urandom);
            bus.iCHAR  = 8'($urandom);
            expSound   = expKey[i] & tone[TB];
            compared++;
            if (bus.oKEY !== expKey[i] || bus.oBUSY !== 1'b1 || bus.oREADY !== 1'b0 || bus.oSOUND !== expSound) begin
                mismatched++;
                $display("FAIL trace char=%h cycle=%0d key/busy/ready/sound=%b%b%b%b required %b10%b",
                         c, i, bus.oKEY, bus.oBUSY, bus.oREADY, bus.oSOUND, expKey[i], expSound);
            end
            step();
        end
        bus.iVALID = 1'b0;
        compared++;
        if (bus.oREADY !== 1'b1 || bus.oBUSY !== 1'b0 || bus.oKEY !== 1'b0) begin
            mismatched++;
            $display("FAIL char_done char=%h ready/busy/key=%b%b%b required 100", c, bus.oREADY, bus.oBUSY, bus.oKEY);
        end
    endtask

    task automatic test_reset();
        bus.iVALID = 1'b0;
        bus.iCHAR  = 8'h00;
        repeat (3) step();
        compared++;
        if ({bus.oREADY, bus.oKEY, bus.oBUSY, bus.oSOUND} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_state ready/key/busy/sound=%b%b%b%b required 0000", bus.oREADY, bus.oKEY, bus.oBUSY, bus.oSOUND);
        end
        iRST = 1'b0;
        #1;
        compared++;
        if (bus.oREADY !== 1'b0) begin
            mismatched++;
            $display("FAIL ready_before_edge oREADY=%b required 0", bus.oREADY);
        end
        step();
        compared++;
        if (bus.oREADY !== 1'b1 || bus.oBUSY !== 1'b0) begin
            mismatched++;
            $display("FAIL ready_after_release ready/busy=%b%b required 10", bus.oREADY, bus.oBUSY);
        end
    endtask

    task automatic test_letter_e();
        sendChar("E");
    endtask

    task automatic test_case_fold();
        sendChar("a");
        sendChar("A");
    endtask

    task automatic test_back_to_back();
        sendChar("S");
        sendChar(" ");
        sendChar("T");
    endtask

    task automatic test_unsupported();
        sendChar("#");
        sendChar(8'h7f);
    endtask

    task automatic test_ignore_idle();
        repeat (5) begin
            step();
            compared++;
            if (bus.oBUSY !== 1'b0 || bus.oKEY !== 1'b0 || bus.oREADY !== 1'b1) begin
                mismatched++;
                $display("FAIL idle_hold busy/key/ready=%b%b%b required 001", bus.oBUSY, bus.oKEY, bus.oREADY);
            end
        end
    endtask

    task automatic test_reset_abort();
        bus.iCHAR  = "0";
        bus.iVALID = 1'b1;
        step();
        bus.iVALID = 1'b0;
        repeat (21) step();
        compared++;
        if (bus.oKEY !== 1'b1) begin
            mismatched++;
            $display("FAIL second_dash_key oKEY=%b required 1", bus.oKEY);
        end
        iRST = 1'b1;
        tone = 0;
        #1;
        compared++;
        if ({bus.oKEY, bus.oBUSY, bus.oREADY, bus.oSOUND} !== 4'b0000) begin
            mismatched++;
            $display("FAIL abort_async key/busy/ready/sound=%b%b%b%b required 0000", bus.oKEY, bus.oBUSY, bus.oREADY, bus.oSOUND);
        end
        step();
        step();
        compared++;
        if ({bus.oKEY, bus.oBUSY, bus.oREADY, bus.oSOUND} !== 4'b0000) begin
            mismatched++;
            $display("FAIL abort_held key/busy/ready/sound=%b%b%b%b required 0000", bus.oKEY, bus.oBUSY, bus.oREADY, bus.oSOUND);
        end
        iRST = 1'b0;
        step();
        compared++;
        if (bus.oREADY !== 1'b1 || bus.oKEY !== 1'b0 || bus.oBUSY !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_release ready/key/busy=%b%b%b required 100", bus.oREADY, bus.oKEY, bus.oBUSY);
        end
        sendChar("E");
    endtask

    task automatic test_random();
        logic [7:0] c;
        int r;
        repeat (25) begin
            r = $urandom_range(0, 38);
            c = (r < 26) ? 8'(r + ($urandom_range(0, 1) ? 65 : 97))
              : (r < 36) ? 8'(r - 26 + 48)
              : (r == 36) ? 8'h20 : 8'($urandom);
            sendChar(c);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_letter_e();
        test_case_fold();
        test_back_to_back();
        test_unsupported();
        test_ignore_idle();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
